// File: rtl/instruction_fetch_pkg.sv
// Shared constants for the fetch stage: reset/NOP values, PC increment and
// instruction field positions.
package instruction_fetch_pkg;

    localparam int unsigned XLEN     = 32;
    localparam int unsigned REG_W    = 5;
    localparam int unsigned CNT_W    = 16;

    localparam logic [XLEN-1:0] PC_RESET = 32'h0000_0000;
    localparam logic [XLEN-1:0] NOP      = 32'h0000_0000;
    localparam int unsigned     PC_STEP  = 4;

    localparam int unsigned RS_MSB = 25;
    localparam int unsigned RS_LSB = 21;
    localparam int unsigned RT_MSB = 20;
    localparam int unsigned RT_LSB = 16;
    localparam int unsigned RD_MSB = 15;
    localparam int unsigned RD_LSB = 11;

    // Word-align a byte address.
    function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] addr);
        return addr & ~XLEN'(3);
    endfunction

endpackage

// File: rtl/hazard_detect.sv
// Load-use hazard compare between the load in EX and the source fields of
// the instruction held in IF/ID.
module hazard_detect
    import instruction_fetch_pkg::*;
(
    input  logic             exMemRead,
    input  logic [REG_W-1:0] exRt,
    input  logic             ifidValid,
    input  logic [REG_W-1:0] rs,
    input  logic [REG_W-1:0] rt,
    output logic             stall
);

    // A load into $zero never produces a value to wait for.
    always_comb begin
        stall = exMemRead & ifidValid & (exRt != REG_W'(0)) &
                ((exRt == rs) | (exRt == rt));
    end

endmodule

// File: rtl/instruction_fetch.sv
// IF stage: PC register, IF/ID pipeline register, load-use stall and
// branch redirect handling, plus a saturating stall-cycle counter.
module instruction_fetch
    import instruction_fetch_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic [XLEN-1:0]  instr,
    input  logic             branchTaken,
    input  logic [XLEN-1:0]  branchTarget,
    input  logic             exMemRead,
    input  logic [REG_W-1:0] exRt,
    output logic [XLEN-1:0]  pc,
    output logic [XLEN-1:0]  ifidPcAdder,
    output logic [XLEN-1:0]  ifidInstr,
    output logic             ifidValid,
    output logic             stall,
    output logic             flush,
    output logic [CNT_W-1:0] stallCount
);

    logic [XLEN-1:0] pc_plus4;

    assign pc_plus4 = pc + XLEN'(PC_STEP);
    assign flush    = branchTaken;

    hazard_detect u_hazard_detect (
        .exMemRead (exMemRead),
        .exRt      (exRt),
        .ifidValid (ifidValid),
        .rs        (ifidInstr[RS_MSB:RS_LSB]),
        .rt        (ifidInstr[RT_MSB:RT_LSB]),
        .stall     (stall)
    );

    // PC and IF/ID: redirect beats stall, stall holds, otherwise advance.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc          <= PC_RESET;
            ifidPcAdder <= XLEN'(0);
            ifidInstr   <= NOP;
            ifidValid   <= 1'b0;
        end else if (branchTaken) begin
            pc          <= word_align(branchTarget);
            ifidPcAdder <= XLEN'(0);
            ifidInstr   <= NOP;
            ifidValid   <= 1'b0;
        end else if (!stall) begin
            pc          <= pc_plus4;
            ifidPcAdder <= pc_plus4;
            ifidInstr   <= instr;
            ifidValid   <= 1'b1;
        end
    end

    // Stall cycles that were not overridden by a redirect, saturating.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stallCount <= CNT_W'(0);
        end else if (stall && !branchTaken && (stallCount != {CNT_W{1'b1}})) begin
            stallCount <= stallCount + CNT_W'(1);
        end
    end

endmodule

// File: doc/instruction_fetch.md
INSTRUCTION_FETCH -- requirements
Module: instruction_fetch

Interface
REQ-001 The block SHALL use one clock and an asynchronous, active-low reset.
REQ-002 clk  in  1  rising-edge clock for every register in the block.
REQ-003 rst_n  in  1  asynchronous active-low reset.
REQ-004 instr  in  32  instruction word read combinationally from instruction memory at address pc.
REQ-005 branchTaken  in  1  resolved taken branch from the MEM stage; this is the redirect request.
REQ-006 branchTarget  in  32  redirect address; valid only while branchTaken=1.
REQ-007 exMemRead  in  1  memory-read control of the instruction currently in EX (ID/EX output).
REQ-008 exRt  in  5  rt field (bits 20:16) of the instruction currently in EX.
REQ-009 pc  out  32  current fetch address driven to instruction memory.
REQ-010 ifidPcAdder  out  32  registered pc+4 of the instruction held in IF/ID.
REQ-011 ifidInstr  out  32  registered instruction held in IF/ID.
REQ-012 ifidValid  out  1  set when IF/ID holds a real instruction; clear when it holds a bubble.
REQ-013 stall  out  1  combinational load-use stall; ID uses it to zero the control signals it feeds into ID/EX.
REQ-014 flush  out  1  combinational copy of branchTaken, sent to downstream stages.
REQ-015 stallCount  out  16  saturating count of stall cycles since reset.

Function
REQ-016 stall SHALL equal exMemRead & ifidValid & (exRt!=0) & (exRt==ifidInstr[25:21] | exRt==ifidInstr[20:16]).
REQ-017 Normal cycle (no stall, no branchTaken): at the clock edge, pc<=pc+4, ifidInstr<=instr, ifidPcAdder<=pc+4 and ifidValid<=1.
REQ-018 Stall cycle (stall=1, branchTaken=0): pc, ifidInstr, ifidPcAdder and ifidValid SHALL hold their values.
REQ-019 A load-use hazard SHALL produce exactly one stall cycle per hazard, because EX holds a bubble on the next cycle.
REQ-020 Redirect (branchTaken=1): pc<={branchTarget[31:2],2'b00}, ifidInstr<=NOP (32'h0), ifidPcAdder<=0 and ifidValid<=0.
REQ-021 branchTaken SHALL take priority over stall when both are asserted in the same cycle.
REQ-022 pc+4 SHALL wrap modulo 2^32, so 0xFFFFFFFC is followed by 0x00000000.
REQ-023 stallCount SHALL increment by 1 on each clock edge where stall=1 and branchTaken=0, and SHALL saturate at 0xFFFF.
REQ-024 pc[1:0] SHALL be 2'b00 at all times.
REQ-025 Latency from instr to ifidInstr SHALL be 1 cycle; a redirect SHALL appear on pc 1 cycle after branchTaken is sampled.

Reset
REQ-026 While rst_n=0: pc=0, ifidPcAdder=0, ifidInstr=0, ifidValid=0 and stallCount=0, asynchronously and regardless of clk.
REQ-027 The combinational outputs SHALL evaluate to stall=0 during reset, because ifidValid=0.
REQ-028 Reset asserted mid-stall or mid-redirect SHALL discard the pending update; the first fetch after release SHALL be from address 0.
REQ-029 The first rising clk edge after rst_n rises SHALL perform a normal cycle.

Structure
REQ-030 A shared package SHALL hold: PC_RESET=32'h0, NOP=32'h0, PC_STEP=4, and the field positions RS=25:21, RT=20:16 and RD=15:11.
REQ-031 The load-use compare SHALL be a combinational sub-module named hazard_detect.
REQ-032 The PC register, the IF/ID register and stallCount SHALL live in instruction_fetch.

Verification
REQ-033 Reset release with instr=32'h8C010000: pc=0 → 4 → 8 on successive edges; the first ifidInstr=32'h8C010000 with ifidPcAdder=4 and ifidValid=1.
REQ-034 Load-use: exMemRead=1, exRt=1, ifidInstr=32'h00221820 (rs=1) → stall=1 for one cycle; pc and IF/ID hold; stallCount=1.
REQ-035 Hazard on $zero: exRt=0 with matching fields → stall=0 and pc advances.
REQ-036 Redirect: branchTaken=1, branchTarget=32'h00000043 → next pc=32'h00000040, ifidInstr=0, ifidValid=0, flush=1 during that cycle.
REQ-037 Simultaneous stall and branchTaken → redirect wins and stallCount does not increment.
REQ-038 Wrap and saturation: pc forced near 0xFFFFFFFC wraps to 0; 65540 consecutive stall cycles leave stallCount=0xFFFF; asserting rst_n=0 mid-stall clears every output immediately.
